// File: rtl/uart_rx_axis.sv
// UART receiver (start / DATA_BITS data LSB-first / stop) feeding an AXI-Stream master through a small FIFO.
// Frames with a bad stop bit pulse frame_err_o and are discarded; axis_last_o marks every PKT_LEN-th accepted byte.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_WAIT_IDLE | wait for a genuinely high synced line before arming
// S_IDLE      | line idle, watching for a falling edge
// S_START     | confirm the start bit at its mid point
// S_DATA      | sample DATA_BITS data bits, one per bit period
// S_STOP      | check the stop bit, then push the byte or report a framing error
module uart_rx_axis #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    parameter int PKT_LEN      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] axis_data_o,
    output logic                 axis_valid_o,
    input  logic                 axis_ready_i,
    output logic                 axis_last_o,
    output logic                 frame_err_o,
    output logic                 overflow_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [PW-1:0] PKT_END  = PW'(PKT_LEN - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic                 rx_meta_q;
    logic                 rx_sync_q;
    logic [1:0]           sync_fill_q;
    logic                 sync_ok;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push;
    logic                 frame_err_q, frame_err_d;

    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS:0]   head;
    logic                 empty, full, pop, push_ok, drop, last_flag;
    logic [PW-1:0]        pkt_cnt_q;
    logic                 overflow_q;

    // The reset value of the synchroniser is not a real line sample; sync_ok
    // goes high only once both flops hold sampled data, so a low data bit left
    // over from a frame interrupted by reset cannot be mistaken for idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            sync_fill_q <= 2'b00;
        end else begin
            rx_meta_q   <= uart_rx_i;
            rx_sync_q   <= rx_meta_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
        end
    end

    assign sync_ok = sync_fill_q[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_WAIT_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (sync_ok && rx_sync_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d                  = '0;
                    shift_d                = shift_q >> 1;
                    shift_d[DATA_BITS-1]   = rx_sync_q;
                    bit_idx_d              = bit_idx_q + 1'b1;
                    if (bit_idx_q == BIT_LAST) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_WAIT_IDLE;
        endcase
    end

    // FIFO with one extra pointer bit to tell full from empty.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = !empty && axis_ready_i;
    assign push_ok   = push && (!full || pop);
    assign drop      = push && !push_ok;
    assign last_flag = (pkt_cnt_q == PKT_END);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok) begin
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                pkt_cnt_q <= last_flag ? '0 : pkt_cnt_q + 1'b1;
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

    // When full, a simultaneous pop frees exactly the slot being written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {last_flag, shift_q};
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign axis_valid_o = !empty;
    assign axis_data_o  = empty ? '0 : head[DATA_BITS-1:0];
    assign axis_last_o  = !empty && head[DATA_BITS];
    assign frame_err_o  = frame_err_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: drives serial frames and checks the AXIS side against a queue model of
// expected {last,data} beats, plus frame-error and overflow bookkeeping.
module tb_uart_rx_axis;

    localparam int DB    = 8;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int PKT   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, last, fe, ovf;

    always #5 clk = ~clk;

    uart_rx_axis #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .PKT_LEN     (PKT)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .uart_rx_i   (rx),
        .axis_data_o (data),
        .axis_valid_o(valid),
        .axis_ready_i(ready),
        .axis_last_o (last),
        .frame_err_o (fe),
        .overflow_o  (ovf)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    logic [8:0] exp_q[$];
    logic [8:0] log_q[$];
    int         model_pkt = 0;
    bit         model_ovf = 1'b0;
    int         fe_exp = 0;
    int         fe_seen = 0;
    int         valid_cycles = 0;
    bit         stall_prev = 1'b0;
    bit         fe_prev = 1'b0;
    logic [8:0] prev_head = '0;
    bit         rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [8:0] last_log();
        return (log_q.size() > 0) ? log_q[log_q.size()-1] : 9'h1FF;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Decides the fate of a frame from the specification's rules: bad stop -> frame error,
    // good stop into a full FIFO -> dropped with overflow, otherwise a beat tagged by packet position.
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) fe_exp++;
        else if (exp_q.size() >= DEPTH) model_ovf = 1'b1;
        else begin
            exp_q.push_back({(model_pkt == PKT - 1), b});
            model_pkt = (model_pkt + 1) % PKT;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            tick(CPB);
        end
        model_frame(b, stop);
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        model_pkt = 0;
        model_ovf = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            fe_prev    = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", 32'({valid, last, data}), 32'({1'b1, prev_head}));
            if (fe) begin
                fe_seen++;
                chk("frame_err_width", 32'(fe_prev), 32'(0));
            end
            if (valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) chk("spurious_valid", 32'(valid), 32'(0));
                else if (ready) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    log_q.push_back({last, data});
                    chk("beat", 32'({last, data}), 32'(e));
                end
            end
            stall_prev = valid && !ready;
            prev_head  = {last, data};
            fe_prev    = fe;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1);
    end

    logic [8:0] pk_exp [6];
    logic [8:0] drain_exp [4];
    logic [7:0] rb;
    bit         rgood;
    int         base, vc0, fe0, guard;

    initial begin
        pk_exp    = '{9'h010, 9'h011, 9'h112, 9'h013, 9'h014, 9'h115};
        drain_exp = '{9'h001, 9'h002, 9'h103, 9'h004};

        tick(2);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_data",  32'(data),  32'(0));
        chk("rst_last",  32'(last),  32'(0));
        chk("rst_ferr",  32'(fe),    32'(0));
        chk("rst_ovf",   32'(ovf),   32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(CPB);

        // single byte, ready held high
        ready = 1'b1;
        vc0 = valid_cycles;
        send(8'hA5, 1'b1);
        tick(2 * CPB);
        chk("a5_beat",   32'(last_log()), 32'(9'h0A5));
        chk("a5_vcyc",   32'(valid_cycles - vc0), 32'(1));
        chk("a5_ferr",   32'(fe_seen), 32'(0));
        chk("a5_ovf",    32'(ovf), 32'(0));

        // short low glitch must not start a frame
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * CPB);
        chk("glitch_beats", 32'(log_q.size()), 32'(1));
        chk("glitch_ferr",  32'(fe_seen), 32'(0));
        send(8'h3C, 1'b1);
        tick(2 * CPB);
        chk("3c_beat", 32'(last_log()), 32'(9'h03C));

        // bad stop bit
        send(8'h3C, 1'b0);
        tick(2 * CPB);
        chk("ferr_count", 32'(fe_seen), 32'(1));
        chk("ferr_beats", 32'(log_q.size()), 32'(2));
        send(8'h55, 1'b1);
        tick(2 * CPB);
        chk("55_beat", 32'(last_log()), 32'(9'h155));

        // overflow with the sink stalled
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1);
            if (i == 4) chk("ovf_before", 32'(ovf), 32'(0));
            if (i == 5) chk("ovf_after",  32'(ovf), 32'(1));
            tick(2);
        end
        tick(10);
        base = log_q.size();
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_valid", 32'(valid), 32'(1));
        end
        @(negedge clk);
        chk("drain_empty", 32'(valid), 32'(0));
        for (int k = 0; k < 4; k++)
            chk("drain_beat", 32'((log_q.size() > base + k) ? log_q[base+k] : 9'h1FF), 32'(drain_exp[k]));
        chk("ovf_sticky", 32'(ovf), 32'(model_ovf));
        tick(1);

        // packet boundaries from a fresh packet count
        do_reset();
        tick(CPB);
        base = log_q.size();
        for (int i = 0; i < 6; i++) begin
            send(8'(8'h10 + i), 1'b1);
            tick(3);
        end
        tick(2 * CPB);
        for (int k = 0; k < 6; k++)
            chk("pkt_beat", 32'((log_q.size() > base + k) ? log_q[base+k] : 9'h1FF), 32'(pk_exp[k]));

        // reset in the middle of a frame, line still low afterwards
        send(8'h20, 1'b1);
        tick(3);
        send(8'h21, 1'b1);
        tick(3);
        base = log_q.size();
        fe0  = fe_seen;
        rx = 1'b0;
        tick(CPB);
        tick(3 * CPB + CPB / 2);
        do_reset();
        chk("midrst_ovf", 32'(ovf), 32'(0));
        tick(5 * CPB - 5);
        rx = 1'b1;
        tick(3 * CPB);
        chk("midrst_beats", 32'(log_q.size()), 32'(base));
        chk("midrst_ferr",  32'(fe_seen), 32'(fe0));
        send(8'h81, 1'b1);
        tick(2 * CPB);
        chk("81_beat", 32'(last_log()), 32'(9'h081));
        send(8'h82, 1'b1);
        tick(3);
        send(8'h83, 1'b1);
        tick(2 * CPB);
        chk("83_beat", 32'(last_log()), 32'(9'h183));

        // randomized frames, random backpressure
        rnd_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            rb    = 8'($urandom_range(0, 255));
            rgood = ($urandom_range(0, 5) != 0);
            send(rb, rgood);
            if (rgood) tick($urandom_range(0, 20));
            else tick($urandom_range(4, 30));
        end
        rnd_ready = 1'b0;
        tick(1);
        ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick(1);
            guard++;
        end
        tick(2);
        chk("final_drained", 32'(exp_q.size()), 32'(0));
        chk("final_ferr",    32'(fe_seen), 32'(fe_exp));
        chk("final_ovf",     32'(ovf), 32'(model_ovf));
        chk("final_valid",   32'(valid), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
